// File: rtl/switch_pkg.sv
// Shared types and defaults for the switch debouncer.
// The channel state enum is exported so checkers can decode dbg_state.
package switch_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } chan_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // The debounced level is high in S_HIGH and while a fall is still unconfirmed.
    function automatic logic is_high_level(input chan_state_e s);
        return (s == S_HIGH) || (s == S_FALL);
    endfunction

endpackage

// File: rtl/switch_chan_fsm.sv
// One switch channel: 2-flop synchronizer, 4-state debounce FSM, output register
// and press/release pulses. Toggle mode exists only when SWITCH_TOGGLE_EN is defined.
module switch_chan_fsm
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw,
`ifdef SWITCH_TOGGLE_EN
    input  logic       mode,
`endif
    output logic       out,
    output logic       press,
    output logic       release_pulse,
    output logic [1:0] dbg_state
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             sw_s;
    chan_state_e      state_q;
    chan_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_q;
    logic             out_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
    logic             level_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
        end
    end

    assign sw_s = sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_LOW;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES further stable samples.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            S_LOW: begin
                if (sw_s) begin
                    state_d = S_RISE;
                    cnt_d   = '0;
                end
            end
            S_RISE: begin
                if (!sw_s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!sw_s) begin
                    state_d = S_FALL;
                    cnt_d   = '0;
                end
            end
            S_FALL: begin
                if (sw_s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_LOW;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_d = is_high_level(state_d);

`ifdef SWITCH_TOGGLE_EN
    // Toggle flips on accepted presses only; follow re-syncs to the level every edge.
    always_comb begin
        out_d = level_d;
        if (mode) begin
            out_d = out_q ^ press_d;
        end
    end
`else
    always_comb begin
        out_d = level_d;
    end
`endif

    assign out           = out_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign dbg_state     = state_q;

    a_no_dual_pulse : assert property (@(posedge clk) disable iff (!reset)
        !(press_q && release_q));
    a_cnt_bounded : assert property (@(posedge clk) disable iff (!reset)
        cnt_q <= CNT_LAST);

endmodule

// File: rtl/switch_debounce_fsm.sv
// Multi-channel switch debouncer top: N_CH independent channels plus any_on.
// Optional toggle mode (and the mode port) is enabled by defining SWITCH_TOGGLE_EN.
// "release" is a reserved word, so the falling-edge pulse port is release_pulse.
module switch_debounce_fsm
    import switch_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic [0:0]        clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   sw,
`ifdef SWITCH_TOGGLE_EN
    input  logic [N_CH-1:0]   mode,
`endif
    output logic [N_CH-1:0]   out,
    output logic [N_CH-1:0]   press,
    output logic [N_CH-1:0]   release_pulse,
    output logic              any_on,
    output logic [2*N_CH-1:0] dbg_state
);

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        switch_chan_fsm #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .sw            (sw[g]),
`ifdef SWITCH_TOGGLE_EN
            .mode          (mode[g]),
`endif
            .out           (out[g]),
            .press         (press[g]),
            .release_pulse (release_pulse[g]),
            .dbg_state     (dbg_state[2*g +: 2])
        );
    end

    assign any_on = |out;

endmodule

// File: tb/tb_switch_debounce_fsm.sv
// Scoreboard bench for switch_debounce_fsm: a run-length reference model pushes the
// expected outputs each edge; a negedge monitor pops and compares them.
module tb_switch_debounce_fsm;

    localparam int N_CH = 4;
    localparam int D    = 4;
    localparam int W    = 3 * N_CH + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N_CH-1:0]   sw = '0;
    logic [N_CH-1:0]   mode = '0;
    logic [N_CH-1:0]   out;
    logic [N_CH-1:0]   press;
    logic [N_CH-1:0]   release_pulse;
    logic              any_on;
    logic [2*N_CH-1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    switch_debounce_fsm #(
        .N_CH(N_CH),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sw            (sw),
`ifdef SWITCH_TOGGLE_EN
        .mode          (mode),
`endif
        .out           (out),
        .press         (press),
        .release_pulse (release_pulse),
        .any_on        (any_on),
        .dbg_state     (dbg_state)
    );

    // Reference: raw sw reaches the debouncer two edges late; a level flips once
    // D+1 consecutive samples disagree with it.
    logic [N_CH-1:0] m_p1  = '0;
    logic [N_CH-1:0] m_p2  = '0;
    logic [N_CH-1:0] m_lvl = '0;
    logic [N_CH-1:0] m_out = '0;
    int              m_run[N_CH];

    always @(posedge clk) begin
        logic [N_CH-1:0] s;
        logic [N_CH-1:0] pr;
        logic [N_CH-1:0] rl;
        logic [N_CH-1:0] md;
        pr = '0;
        rl = '0;
        if (!reset) begin
            m_p1  = '0;
            m_p2  = '0;
            m_lvl = '0;
            m_out = '0;
            for (int c = 0; c < N_CH; c++) m_run[c] = 0;
        end else begin
            s    = m_p2;
            m_p2 = m_p1;
            m_p1 = sw;
`ifdef SWITCH_TOGGLE_EN
            md = mode;
`else
            md = '0;
`endif
            for (int c = 0; c < N_CH; c++) begin
                if (s[c] != m_lvl[c]) m_run[c] = m_run[c] + 1;
                else                  m_run[c] = 0;
                if (m_run[c] == D + 1) begin
                    m_lvl[c] = s[c];
                    m_run[c] = 0;
                    pr[c]    = s[c];
                    rl[c]    = ~s[c];
                end
                m_out[c] = md[c] ? (m_out[c] ^ pr[c]) : m_lvl[c];
            end
        end
        exp_q.push_back({m_out, pr, rl, |m_out});
    end

    task automatic chk(input string nm, input logic [N_CH-1:0] act,
                       input logic [N_CH-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out",     out,           e[3*N_CH -: N_CH]);
            chk("press",   press,         e[2*N_CH -: N_CH]);
            chk("release", release_pulse, e[N_CH -: N_CH]);
            chk("any_on",  {{(N_CH-1){1'b0}}, any_on}, {{(N_CH-1){1'b0}}, e[0]});
        end
    end

    task automatic drive(input logic [N_CH-1:0] s, input logic [N_CH-1:0] m,
                         input logic r, input int n);
        @(negedge clk);
        #1;
        sw    = s;
        mode  = m;
        reset = r;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        logic [N_CH-1:0] cur_sw;
        logic [N_CH-1:0] cur_mode;
        logic            cur_rst;
        sw    = 4'b1111;
        reset = 1'b0;
        repeat (20) @(posedge clk);

        drive(4'b0000, 4'b0000, 1'b1, 5);
        drive(4'b0001, 4'b0000, 1'b1, 12);

        drive(4'b0011, 4'b0000, 1'b1, 3);
        drive(4'b0001, 4'b0000, 1'b1, 8);
        drive(4'b0011, 4'b0000, 1'b1, 12);
        drive(4'b0001, 4'b0000, 1'b1, 3);
        drive(4'b0011, 4'b0000, 1'b1, 10);
        drive(4'b0000, 4'b0000, 1'b1, 12);

        drive(4'b0100, 4'b0100, 1'b1, 10);
        drive(4'b0000, 4'b0100, 1'b1, 10);
        drive(4'b0100, 4'b0100, 1'b1, 10);
        drive(4'b0000, 4'b0100, 1'b1, 10);
        drive(4'b0000, 4'b0000, 1'b1, 4);

        drive(4'b1111, 4'b0000, 1'b1, 12);
        drive(4'b0000, 4'b0000, 1'b1, 12);

        drive(4'b1000, 4'b0000, 1'b1, 5);
        drive(4'b1000, 4'b0000, 1'b0, 2);
        drive(4'b1000, 4'b0000, 1'b1, 12);
        drive(4'b0000, 4'b0000, 1'b1, 12);

        cur_sw   = '0;
        cur_mode = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 3) == 0)  cur_sw[c]   = ~cur_sw[c];
                if ($urandom_range(0, 39) == 0) cur_mode[c] = ~cur_mode[c];
            end
            cur_rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            drive(cur_sw, cur_mode, cur_rst, $urandom_range(1, 8));
        end

        drive(4'b0000, 4'b0000, 1'b1, 20);
        @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog at %0t: got timeout expected completion", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_debounce_fsm.md
Name: switch_debounce_fsm

Overview:
- Parametrised, multi-channel successor to the single-switch on/off FSM.
- Each channel does the following:
  - synchronises a raw board switch or button;
  - debounces it with a 4-state FSM;
  - drives a registered output, either following the switch level or toggling on each press;
  - emits one-cycle press and release pulses.
- Sits between board switch pins and the LED/game-logic FSMs of the final project.

Parameters:
- N_CH, 4: number of independent switch channels (≥1).
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to accept a level change (≥1).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width (localparam, derived).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted = 0).
- sw  input  N_CH  raw, asynchronous switch levels.
- mode  input  N_CH  per-channel mode: 0 = follow, 1 = toggle. Present only with SWITCH_TOGGLE_EN.
- out  output  N_CH  registered channel outputs.
- press  output  N_CH  one-cycle pulse on debounced rising level.
- release  output  N_CH  one-cycle pulse on debounced falling level.
- any_on  output  1  OR of out.

Behaviour:
- Reset (reset = 0, asynchronous):
  - sync flops, state, cnt, out, press and release are all 0 for every channel;
  - every channel state = S_LOW;
  - any_on = 0.
- Synchronizer: two flops per channel, giving sw_s. No logic sits between the two flops.
- Channel FSM states (2-bit enum): S_LOW, S_RISE, S_HIGH, S_FALL.
- S_LOW:
  - sw_s = 1: go to S_RISE, cnt <= 0.
  - Otherwise stay.
- S_RISE:
  - sw_s = 0: go to S_LOW, cnt <= 0 (glitch rejected, no pulse).
  - Else if cnt == DEBOUNCE_CYCLES-1: go to S_HIGH, press <= 1.
  - Else cnt++.
- S_HIGH:
  - sw_s = 0: go to S_FALL, cnt <= 0.
  - Otherwise stay.
- S_FALL:
  - sw_s = 1: go to S_HIGH, cnt <= 0 (no pulse).
  - Else if cnt == DEBOUNCE_CYCLES-1: go to S_LOW, release <= 1.
  - Else cnt++.
- Counter rules: cnt never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible. cnt is cleared on every state entry.
- press and release:
  - Registered; high exactly one cycle per accepted transition.
  - Never both high on the same channel in the same cycle.
- Latency:
  - Count clock edges from the first edge that samples sw high.
  - The S_LOW→S_RISE transition happens at edge 3.
  - press and out (follow mode) rise at edge DEBOUNCE_CYCLES+3.
  - Release latency is symmetric.
- Follow mode (mode = 0): out is updated at the same edge as the HIGH/LOW transition. out equals the debounced level (state ∈ {S_HIGH, S_FALL}).
- Toggle mode (mode = 1): out inverts at the edge where press is set. Release has no effect on out.
- Mode switching:
  - mode is sampled each edge.
  - Toggle→follow: out <= debounced level at the next edge.
  - Follow→toggle: out holds its value.
- Channel independence: channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.
- any_on is combinational from the registered out.
- Reset mid-debounce: the channel returns to S_LOW and any pending transition is discarded. A switch still high after release of reset re-debounces from S_LOW.

Optional Feature:
- Macro: SWITCH_TOGGLE_EN.
- Defined:
  - mode port exists;
  - toggle mode behaves as above.
- Undefined:
  - no mode port;
  - every channel is hard-wired to follow mode;
  - the toggle register path is removed.

Decomposition:
- Package switch_pkg holds:
  - the typedef enum logic [1:0] for S_LOW/S_RISE/S_HIGH/S_FALL;
  - the default DEBOUNCE_CYCLES constant.
- Sub-module switch_chan_fsm: one channel containing synchronizer, FSM, counter, out and pulses. It is instantiated N_CH times in a generate loop.
- Top level adds any_on.

Test Plan:
- Reset:
  - Stimulus: reset = 0 with sw = 4'b1111 held 20 cycles.
  - Required response: out = 0, press = 0, release = 0 and any_on = 0 throughout.
- Clean press:
  - Stimulus: after reset release, set sw[0] = 1 (DEBOUNCE_CYCLES = 4).
  - Required response: press[0] for one cycle after edge 7 and out[0] = 1 from edge 7; other channels stay 0.
- Glitch rejection:
  - Stimulus: sw[1] = 1 for 3 cycles, then 0.
  - Required response: no press[1], out[1] stays 0.
  - Stimulus: same on falling side while HIGH.
  - Required response: no release[1].
- Toggle (SWITCH_TOGGLE_EN, mode[2] = 1):
  - Stimulus: two clean presses on sw[2].
  - Required response: out[2] goes 0→1→0; release pulses occur but leave out[2] unchanged.
- Simultaneous channels:
  - Stimulus: sw = 4'b1111 on one edge.
  - Required response: press = 4'b1111 in the same cycle, any_on = 1.
- Mid-debounce reset:
  - Stimulus: sw[3] = 1, assert reset at cnt = 2, release reset with sw[3] still 1.
  - Required response: full DEBOUNCE_CYCLES+3 latency is restarted before press[3].
